// File: rtl/trace_ctrl_if.sv
// Host config bus plus tracer-side and assembler-side packet streams of trace_ctrl.
// Both streams are strobe-only (no back-pressure): a packet exists on any cycle its strobe is high.
interface trace_ctrl_if;
  logic [15:0] config_addr;
  logic [15:0] config_data;
  logic        config_strobe;
  logic        in_strobe;
  logic [1:0]  in_type;
  logic [22:0] in_payload;
  logic        out_strobe;
  logic [1:0]  out_type;
  logic [22:0] out_payload;

  modport master (
    output config_addr, config_data, config_strobe, in_strobe, in_type, in_payload,
    input  out_strobe, out_type, out_payload
  );
  modport slave (
    input  config_addr, config_data, config_strobe, in_strobe, in_type, in_payload,
    output out_strobe, out_type, out_payload
  );
endinterface

// File: rtl/trace_ctrl.sv
// Trace sequencer: config registers, trigger FSM and packet gating with marker insertion.
// Optional compare mask registers are built only when TRACE_CTRL_MASK_EN is defined.
module trace_ctrl #(
  parameter logic [15:0] CTRL_RESET = 16'h0003,
  parameter int          LEN_W      = 16
) (
  input  logic             mclk,
  input  logic             reset,
  trace_ctrl_if.slave      bus,
  output logic             trace_enable,
  output logic             trace_reads,
  output logic             turbo,
  output logic [1:0]       trig_state,
  output logic [LEN_W-1:0] capture_count
);

  typedef enum logic [1:0] {IDLE = 2'd0, ARMED = 2'd1, CAPTURE = 2'd2, DONE = 2'd3} state_t;

  state_t           state;
  logic             trig_mode;
  logic [22:0]      trig_addr;
  logic [22:0]      mask;
  logic [LEN_W-1:0] cap_len;
  logic             hold_valid;
  logic [1:0]       hold_type;
  logic [22:0]      hold_payload;

  logic             ctrl_wr, arm, abort, flush;
  logic             addr_match, trigger, take, is_word;
  logic [LEN_W-1:0] count_inc;

  assign trig_state = state;

  always_comb begin
    ctrl_wr    = bus.config_strobe && (bus.config_addr == 16'h0000);
    abort      = ctrl_wr && bus.config_data[4];
    arm        = ctrl_wr && bus.config_data[3] && !bus.config_data[4];
    flush      = arm || abort;
    addr_match = (((bus.in_payload ^ trig_addr) & mask) == 23'd0);
    // A same-cycle ARM/ABORT write outranks whatever the packet would have done.
    trigger    = trig_mode && (state == ARMED) && bus.in_strobe && !flush &&
                 (bus.in_type == 2'b00) && addr_match;
    take       = bus.in_strobe &&
                 (!trig_mode || ((state == CAPTURE) && !flush));
    is_word    = (bus.in_type == 2'b01) || (bus.in_type == 2'b10);
    count_inc  = (&capture_count) ? capture_count : capture_count + 1'b1;
  end

  // Host-visible configuration registers.
  always_ff @(posedge mclk or posedge reset) begin
    if (reset) begin
      trace_enable <= CTRL_RESET[0];
      trace_reads  <= CTRL_RESET[1];
      turbo        <= CTRL_RESET[2];
      trig_mode    <= CTRL_RESET[5];
      trig_addr    <= 23'd0;
      cap_len      <= '0;
    end else if (bus.config_strobe) begin
      case (bus.config_addr)
        16'h0000: begin
          trace_enable <= bus.config_data[0];
          trace_reads  <= bus.config_data[1];
          turbo        <= bus.config_data[2];
          trig_mode    <= bus.config_data[5];
        end
        16'h0001: trig_addr[15:0]  <= bus.config_data;
        16'h0002: trig_addr[22:16] <= bus.config_data[6:0];
        16'h0005: cap_len          <= LEN_W'(bus.config_data);
        default: ;
      endcase
    end
  end

`ifdef TRACE_CTRL_MASK_EN
  always_ff @(posedge mclk or posedge reset) begin
    if (reset) begin
      mask <= 23'h7FFFFF;
    end else if (bus.config_strobe) begin
      if (bus.config_addr == 16'h0003) mask[15:0]  <= bus.config_data;
      if (bus.config_addr == 16'h0004) mask[22:16] <= bus.config_data[6:0];
    end
  end
`else
  assign mask = 23'h7FFFFF;
`endif

  // Trigger FSM, capture counter and the registered output / hold stage.
  always_ff @(posedge mclk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      capture_count <= '0;
      hold_valid    <= 1'b0;
      hold_type     <= 2'b00;
      hold_payload  <= 23'd0;
      bus.out_strobe  <= 1'b0;
      bus.out_type    <= 2'b00;
      bus.out_payload <= 23'd0;
    end else begin
      if (abort) begin
        state <= IDLE;
      end else if (arm) begin
        state         <= ARMED;
        capture_count <= '0;
      end else if (!trig_mode) begin
        state <= IDLE;
      end else begin
        case (state)
          ARMED:   if (trigger) state <= CAPTURE;
          CAPTURE: if (take && is_word) begin
            capture_count <= count_inc;
            if ((cap_len != '0) && (count_inc == cap_len)) state <= DONE;
          end
          default: ;
        endcase
      end

      // While hold is occupied the stream runs one extra cycle late; a new input refills it.
      if (hold_valid && !flush) begin
        bus.out_strobe  <= 1'b1;
        bus.out_type    <= hold_type;
        bus.out_payload <= hold_payload;
        hold_valid      <= take;
        if (take) begin
          hold_type    <= bus.in_type;
          hold_payload <= bus.in_payload;
        end
      end else if (trigger) begin
        bus.out_strobe  <= 1'b1;
        bus.out_type    <= 2'b11;
        bus.out_payload <= 23'd0;
        hold_valid      <= 1'b1;
        hold_type       <= 2'b00;
        hold_payload    <= bus.in_payload;
      end else begin
        hold_valid     <= 1'b0;
        bus.out_strobe <= take;
        if (take) begin
          bus.out_type    <= bus.in_type;
          bus.out_payload <= bus.in_payload;
        end
      end
    end
  end

endmodule

// File: doc/trace_ctrl.md
Name: trace_ctrl

Overview:
- Trace sequencer placed between the tracing state machine and the USB packet assembler.
- Owns the host-writable config registers and drives the trace_enable, trace_reads and turbo knobs.
- Gates the trace packet stream through a trigger state machine: idle, armed on an address match, capture N words, done.
- On trigger, injects a marker packet so the host can find the capture start.

Parameters:
- CTRL_RESET, 16'h0003, CTRL register value after reset (enable=1, reads=1, turbo=0, free-run).
- LEN_W, 16, width of capture length and capture counter.

Ports:
- mclk  in  1  system clock, 48 MHz
- reset  in  1  asynchronous, active-high
- config_addr  in  16  host register address
- config_data  in  16  host register write data
- config_strobe  in  1  one-cycle register write
- in_strobe  in  1  packet valid from tracer
- in_type  in  2  00 addr, 01 read, 10 write, 11 timestamp
- in_payload  in  23  packet payload
- out_strobe  out  1  packet valid to assembler
- out_type  out  2  forwarded type
- out_payload  out  23  forwarded payload
- trace_enable  out  1  CTRL[0]
- trace_reads  out  1  CTRL[1]
- turbo  out  1  CTRL[2]
- trig_state  out  2  0 IDLE, 1 ARMED, 2 CAPTURE, 3 DONE
- capture_count  out  LEN_W  word packets forwarded since trigger

Behaviour:
- Registers (writes only, unknown addresses ignored):
  - 0x0000 CTRL: [0] enable, [1] reads, [2] turbo, [5] trig_mode. Bits [3] ARM and [4] ABORT are self-clearing strobes and are not stored.
  - 0x0001 TRIG_LO: trigger address [15:0].
  - 0x0002 TRIG_HI: [6:0] = trigger address [22:16].
  - 0x0003 MASK_LO and 0x0004 MASK_HI: compare mask, same layout as TRIG_LO/TRIG_HI.
  - 0x0005 CAP_LEN: capture length in words; 0 = unlimited.
- Reset values: CTRL=CTRL_RESET; TRIG=0; MASK=23'h7FFFFF; CAP_LEN=0; trig_state=IDLE; capture_count=0; out_strobe=0, out_type=0, out_payload=0; hold stage empty.
- Register writes take effect on the next cycle.
- Output path: registered, fixed 1-cycle latency from input to output. One extra hold stage exists only for marker insertion.
- Free-run mode (trig_mode=0): every input packet is forwarded. The state machine stays IDLE.
- Triggered mode (trig_mode=1):
  - IDLE: drop all packets.
  - ARMED: drop packets. Match condition = type 00 and ((payload ^ TRIG) & MASK)==0.
  - On match: output marker (type 11, payload 0) next cycle, load the address packet into hold, go to CAPTURE. Real timestamp packets never carry payload 0.
  - CAPTURE: forward all types. Each forwarded type 01/10 packet increments capture_count, saturating at all-ones. When CAP_LEN!=0 and the increment reaches CAP_LEN, forward that packet and go to DONE.
  - DONE: drop all packets. capture_count holds.
- Hold stage: while hold is valid, each cycle outputs hold. An input arriving that cycle replaces hold, so the stream runs 2 cycles late until the first input-free cycle drains it. Packets are never dropped in CAPTURE.
- ARM in any state: capture_count=0, go to ARMED, hold flushed.
- ABORT: go to IDLE, hold flushed.
- ARM and ABORT in the same write: ABORT wins.
- Packet counts toward termination at acceptance, not at output.
- Match and ARM write in the same cycle: ARM wins, no trigger.
- Clearing trig_mode while in any triggered state: go to IDLE.
- Reset mid-capture: all state returns to reset values immediately.

Optional Feature:
- Macro TRACE_CTRL_MASK_EN.
- Defined: MASK_LO/MASK_HI implemented as described.
- Undefined: mask registers absent and writes to 0x0003/0x0004 ignored; match is exact on all 23 bits.

Test Plan:
- Reset, no writes -> trace_enable=1, trace_reads=1, turbo=0, trig_state=0. Input type 10 payload 0x12345 -> out_strobe 1 cycle later, same type/payload.
- Write CTRL=0x0004 -> turbo=1, trace_enable=0 one cycle later.
- CTRL=0x0023 (mode+enable+reads; ARM bit3 not set), TRIG=0x000100, then CTRL=0x002B (ARM). Addr packet 0x000200 -> dropped. Addr packet 0x000100 -> outputs marker (11, 0) then (00, 0x000100), trig_state=2.
- CAP_LEN=3 in CAPTURE, back-to-back read/write/timestamp/read/write inputs -> 4 packets forwarded (3 words + timestamp), fifth dropped, trig_state=3, capture_count=3.
- Back-to-back inputs on the trigger cycle and the following 2 cycles -> all forwarded in order, 2-cycle latency, none lost.
- MASK=0x7FFF00, TRIG=0x000100, addr 0x0001AB -> triggers. Without TRACE_CTRL_MASK_EN -> no trigger.
